sc_fifo: RTL and testbench

SC_FIFO -- requirements
Module: sc_fifo

---
 rtl/sc_fifo_pkg.sv | 15 +
 rtl/sc_fifo_mem.sv | 37 +++
 rtl/sc_fifo.sv | 114 +++++++++++
 tb/tb_sc_fifo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sc_fifo_pkg.sv
// sc_fifo_pkg: default geometry for sc_fifo and the address-width helper.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sc_fifo_pkg;

   localparam int SC_FIFO_DATA_W = 4;
   localparam int SC_FIFO_DEPTH  = 8;
   localparam int SC_FIFO_ADDR_W = $clog2(SC_FIFO_DEPTH);

   // Pointer width for a given depth; depth 1 would give 0 bits, so clamp to 1.
   function automatic int addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/sc_fifo_mem.sv
// sc_fifo_mem: DEPTH x DATA_W storage, synchronous write, asynchronous read.
// Latency: write lands at the rising edge, read data is combinational from the address.
// Backpressure: none; the caller gates i_wr_en. Contents are not reset.
//
// Ports:
//   clk        rising-edge clock for the write port
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_dat   write data
//   i_rd_addr  read address
//   o_rd_dat   read data (combinational)
module sc_fifo_mem
   import sc_fifo_pkg::*;
#(
   parameter int DATA_W = SC_FIFO_DATA_W,
   parameter int DEPTH  = SC_FIFO_DEPTH,
   parameter int AW     = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_dat,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [DATA_W-1:0] o_rd_dat
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_dat;
      end
   end

   assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/sc_fifo.sv
// sc_fifo: single-clock FIFO with registered read data.
// Latency: data_out updates at the edge that accepts a read (1 cycle after rd).
// Backpressure: writes ignored while full, reads ignored while empty; full/empty are registered-state flags.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   data_in, wr   write data and write request
//   rd            read request
//   data_out      registered read data, holds when no read is accepted
//   full, empty   occupancy flags
//   overflow, underflow  sticky error flags, present only with SC_FIFO_ERR_FLAGS_EN defined
module sc_fifo
   import sc_fifo_pkg::*;
#(
   parameter int DATA_W = SC_FIFO_DATA_W,
   parameter int DEPTH  = SC_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd,
   input  logic              wr,
   output logic [DATA_W-1:0] data_out,
   output logic              full,
   output logic              empty
`ifdef SC_FIFO_ERR_FLAGS_EN
   ,
   output logic              overflow,
   output logic              underflow
`endif
);

   localparam int             AW       = addr_w(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [DATA_W-1:0] r_data_out;

   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [DATA_W-1:0] w_rd_dat;

   assign full  = (r_count == FULL_CNT);
   assign empty = (r_count == '0);

   // Acceptance uses the registered flags, so a full FIFO still takes the
   // read of a simultaneous rd/wr and an empty one still takes the write.
   assign w_wr_acc = wr & ~full;
   assign w_rd_acc = rd & ~empty;

   sc_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_dat  (data_in),
      .i_rd_addr (r_rd_ptr),
      .o_rd_dat  (w_rd_dat)
   );

   // DEPTH is a power of two, so natural AW-bit overflow is the wrap to 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_data_out <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_data_out <= w_rd_dat;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign data_out = r_data_out;

`ifdef SC_FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky: any rejected request sets its flag, only reset clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr && full) begin
            r_overflow <= 1'b1;
         end
         if (rd && empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sc_fifo.sv
// tb_sc_fifo: directed and randomized checks of sc_fifo against a queue model.
// Latency: model updates at each rising edge, outputs compared 1 ns later.
// Backpressure: model drops writes when holding DEPTH words and reads when holding none.
module tb_sc_fifo;

   localparam int DATA_W = 4;
   localparam int DEPTH  = 8;

   logic              clk;
   logic              reset_n;
   logic [DATA_W-1:0] data_in;
   logic              rd;
   logic              wr;
   logic [DATA_W-1:0] data_out;
   logic              full;
   logic              empty;
`ifdef SC_FIFO_ERR_FLAGS_EN
   logic              overflow;
   logic              underflow;
`endif

   sc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .data_in   (data_in),
      .rd        (rd),
      .wr        (wr),
      .data_out  (data_out),
      .full      (full),
      .empty     (empty)
`ifdef SC_FIFO_ERR_FLAGS_EN
      ,
      .overflow  (overflow),
      .underflow (underflow)
`endif
   );

   // Posedges at 7, 17, 27, ... so a 35 ns reset releases between edges.
   initial begin
      clk = 1'b0;
      #2;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: contents as an ordered queue, plus the output register.
   logic [DATA_W-1:0] q[$];
   logic [DATA_W-1:0] m_dout;
   logic              m_ovf;
   logic              m_unf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".dout"},  32'(data_out), 32'(m_dout));
      check({tag, ".full"},  32'(full),     32'(q.size() == DEPTH));
      check({tag, ".empty"}, 32'(empty),    32'(q.size() == 0));
`ifdef SC_FIFO_ERR_FLAGS_EN
      check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
      check({tag, ".unf"},   32'(underflow), 32'(m_unf));
`endif
   endtask

   // Called 1 ns after a posedge; drives inputs, advances one edge, then compares.
   task automatic cycle(input string tag, input logic r, input logic w, input logic [DATA_W-1:0] d);
      logic rd_ok;
      logic wr_ok;
      rd      = r;
      wr      = w;
      data_in = d;
      rd_ok   = r && (q.size() != 0);
      wr_ok   = w && (q.size() != DEPTH);
      if (w && q.size() == DEPTH) m_ovf = 1'b1;
      if (r && q.size() == 0)     m_unf = 1'b1;
      @(posedge clk);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      #1;
      check_outputs(tag);
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   initial begin
      rd      = 1'b0;
      wr      = 1'b0;
      data_in = '0;
      reset_n = 1'b0;
      model_reset();

      // Reset held 35 ns, sampled across several edges.
      #1;
      check_outputs("rst0");
      for (int i = 0; i < 3; i++) begin
         #10;
         check_outputs("rst_hold");
      end
      #4;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("rst_rel");

      // Idle with random data_in.
      for (int i = 0; i < 32; i++) begin
         cycle("idle", 1'b0, 1'b0, DATA_W'($urandom));
      end

      // Fill 1..8, write 9 while full, then drain.
      for (int i = 1; i <= 8; i++) begin
         cycle("fill", 1'b0, 1'b1, DATA_W'(i));
      end
      check("fill.full8", 32'(full), 32'd1);
      cycle("wr_full", 1'b0, 1'b1, DATA_W'(9));
      for (int i = 1; i <= 8; i++) begin
         cycle("drain", 1'b1, 1'b0, '0);
         check("drain.order", 32'(data_out), 32'(i));
      end
      check("drain.empty", 32'(empty), 32'd1);

      // Boundary: read while empty, then simultaneous rd/wr while empty.
      cycle("rd_empty", 1'b1, 1'b0, 4'h5);
      check("rd_empty.hold", 32'(data_out), 32'd8);
      cycle("rdwr_empty", 1'b1, 1'b1, 4'hA);
      check("rdwr_empty.notempty", 32'(empty), 32'd0);
      cycle("rd_A", 1'b1, 1'b0, '0);
      check("rd_A.val", 32'(data_out), 32'hA);
      check("rd_A.empty", 32'(empty), 32'd1);

      // Concurrent: 3 stored, then 10 cycles of rd=wr=1 crossing the wrap.
      for (int i = 0; i < 3; i++) begin
         cycle("conc_fill", 1'b0, 1'b1, DATA_W'($urandom));
      end
      for (int i = 0; i < 10; i++) begin
         cycle("conc", 1'b1, 1'b1, DATA_W'($urandom));
         check("conc.count", 32'(q.size()), 32'd3);
      end

      // Randomized traffic with phases biased toward filling and toward draining.
      for (int i = 0; i < 600; i++) begin
         int unsigned bias;
         bias = (i / 100) % 3;
         cycle("rand",
               ($urandom_range(99) < (bias == 0 ? 30 : (bias == 1 ? 70 : 50))),
               ($urandom_range(99) < (bias == 0 ? 70 : (bias == 1 ? 30 : 50))),
               DATA_W'($urandom));
      end

      // Mid-operation reset with 5 words stored; make sure both error flags are set first.
      while (q.size() != 0) cycle("pre_drain", 1'b1, 1'b0, '0);
      cycle("pre_unf", 1'b1, 1'b0, '0);
      for (int i = 0; i < DEPTH; i++) cycle("pre_fill", 1'b0, 1'b1, DATA_W'($urandom));
      cycle("pre_ovf", 1'b0, 1'b1, DATA_W'($urandom));
      for (int i = 0; i < DEPTH - 5; i++) cycle("pre_trim", 1'b1, 1'b0, '0);
      check("mid.five", 32'(q.size()), 32'd5);
      check("mid.notempty", 32'(empty), 32'd0);
`ifdef SC_FIFO_ERR_FLAGS_EN
      check("mid.ovf_set", 32'(overflow), 32'd1);
      check("mid.unf_set", 32'(underflow), 32'd1);
`endif
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_outputs("mid_rst");
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("post_rst");

      // Fresh-empty behaviour after the reset.
      cycle("post_rd", 1'b1, 1'b0, '0);
      for (int i = 0; i < 40; i++) begin
         cycle("post_rand", 1'($urandom_range(1)), 1'($urandom_range(1)), DATA_W'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
